// File: rtl/display_pkg.sv
// Shared types and constants for the GPIO 7-segment display output stage.
//   disp_state_t : conversion FSM states
//   SEG_BLANK    : all segments off (active-high)
//   SEG_DASH     : segment g only (active-high)
//   SEG_TABLE    : active-high gfedcba codes for hex digits 0..F, indexed by nibble
//   BCD_DIGITS   : decimal digits produced by the binary-to-BCD converter
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } disp_state_t;

  localparam int unsigned BCD_DIGITS = 10;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Entry 15 first so SEG_TABLE[n] is the code for nibble n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_encode.sv
// Combinational single-digit 7-segment encoder.
//   nibble : digit value 0..F
//   blank  : force all segments off
//   dash   : force a dash (takes priority over blank)
//   seg    : segments g..a, polarity set by ACTIVE_LOW
module seg7_encode
  import display_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  logic [6:0] raw;

  always_comb begin
    raw = SEG_TABLE[nibble];
    if (blank) raw = SEG_BLANK;
    if (dash)  raw = SEG_DASH;
    seg = ACTIVE_LOW ? ~raw : raw;
  end

endmodule

// File: rtl/gpio_seg7_display.sv
// Drives DIGITS 7-segment digits from a 32-bit GPIO word, in hex or unsigned decimal.
// Decimal conversion is a sequential double-dabble, one bit per cycle.
//   clk      : clock
//   rst      : asynchronous active-high reset
//   value_in : word to display
//   mode_dec : 1 = unsigned decimal, 0 = hex
//   hex_out  : digit k on [7k+6:7k], bit order g..a, digit 0 least significant
//   busy     : conversion in progress
//   overflow : displayed value does not fit in DIGITS digits
module gpio_seg7_display
  import display_pkg::*;
#(
  parameter int unsigned DIGITS     = 8,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           value_in,
  input  logic                  mode_dec,
  output logic [DIGITS*7-1:0]   hex_out,
  output logic                  busy,
  output logic                  overflow
);

  localparam logic [6:0] BLANK_OUT = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  disp_state_t             state_q, state_d;
  logic [31:0]             shadow_val_q, shadow_val_d;
  logic                    shadow_mode_q, shadow_mode_d;
  logic                    pending_q, pending_d;
  logic [31:0]             sr_q, sr_d;
  logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [DIGITS*7-1:0]     hex_out_q, hex_out_d;
  logic                    overflow_q, overflow_d;

  logic [4*BCD_DIGITS-1:0] bcd_adj;
  logic [DIGITS-1:0][3:0]  dig_nib;
  logic [DIGITS-1:0]       dig_blank;
  logic [DIGITS-1:0]       dig_dash;
  logic [DIGITS*7-1:0]     seg_flat;
  logic                    dec_ovf;
  logic                    hex_ovf;
  logic                    trigger;

  // Double-dabble correction: nibbles >= 5 get +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign dec_ovf = |(bcd_q >> (4 * DIGITS));
  assign hex_ovf = |(shadow_val_q >> (4 * DIGITS));

  // Per-digit encoder controls, only sampled in UPDATE.
  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      if (shadow_mode_q) begin
        dig_nib[k]   = bcd_q[4*k +: 4];
        dig_dash[k]  = dec_ovf;
        // Leading-zero blanking; digit 0 always shown so zero reads "0".
        dig_blank[k] = (k != 0) && ((bcd_q >> (4 * k)) == '0);
      end else begin
        dig_nib[k]   = shadow_val_q[4*k +: 4];
        dig_dash[k]  = 1'b0;
        dig_blank[k] = 1'b0;
      end
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    seg7_encode #(
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_enc (
      .nibble(dig_nib[k]),
      .blank (dig_blank[k]),
      .dash  (dig_dash[k]),
      .seg   (seg_flat[7*k +: 7])
    );
  end

  assign trigger = pending_q || (value_in != shadow_val_q) || (mode_dec != shadow_mode_q);

  always_comb begin
    state_d       = state_q;
    shadow_val_d  = shadow_val_q;
    shadow_mode_d = shadow_mode_q;
    pending_d     = pending_q;
    sr_d          = sr_q;
    bcd_d         = bcd_q;
    cnt_d         = cnt_q;
    hex_out_d     = hex_out_q;
    overflow_d    = overflow_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          shadow_val_d  = value_in;
          shadow_mode_d = mode_dec;
          pending_d     = 1'b0;
          sr_d          = value_in;
          bcd_d         = '0;
          cnt_d         = '0;
          state_d       = mode_dec ? SHIFT : UPDATE;
        end
      end
      SHIFT: begin
        bcd_d = (bcd_adj << 1) | {{(4*BCD_DIGITS-1){1'b0}}, sr_q[31]};
        sr_d  = sr_q << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = UPDATE;
      end
      UPDATE: begin
        hex_out_d  = seg_flat;
        overflow_d = shadow_mode_q ? dec_ovf : hex_ovf;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      shadow_val_q  <= '0;
      shadow_mode_q <= 1'b0;
      pending_q     <= 1'b1;
      sr_q          <= '0;
      bcd_q         <= '0;
      cnt_q         <= '0;
      hex_out_q     <= {DIGITS{BLANK_OUT}};
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_val_q  <= shadow_val_d;
      shadow_mode_q <= shadow_mode_d;
      pending_q     <= pending_d;
      sr_q          <= sr_d;
      bcd_q         <= bcd_d;
      cnt_q         <= cnt_d;
      hex_out_q     <= hex_out_d;
      overflow_q    <= overflow_d;
    end
  end

  assign hex_out  = hex_out_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_gpio_seg7_display.sv
// Self-checking bench for gpio_seg7_display (DIGITS=8, ACTIVE_LOW=1).
// Outputs are sampled on the falling clock edge; inputs are driven there too.
module tb_gpio_seg7_display;

  localparam int D = 8;

  localparam logic [6:0] SEG_AH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic           clk = 1'b0;
  logic           rst;
  logic [31:0]    value_in;
  logic           mode_dec;
  logic [D*7-1:0] hex_out;
  logic           busy;
  logic           overflow;

  int errors = 0;
  int checks = 0;

  logic [31:0] prev_v;
  bit          prev_dec;
  bit          prev_pending;

  gpio_seg7_display #(
    .DIGITS    (D),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .value_in(value_in),
    .mode_dec(mode_dec),
    .hex_out (hex_out),
    .busy    (busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Expected active-low display, built from digit arithmetic.
  function automatic logic [D*7-1:0] model_disp(input logic [31:0] v, input bit dec);
    logic [D*7-1:0] r;
    longint unsigned x;
    int ndig;
    r = '0;
    if (!dec) begin
      for (int k = 0; k < D; k++) r[7*k +: 7] = ~SEG_AH[(v >> (4 * k)) & 32'hF];
    end else if (v >= 32'd100000000) begin
      for (int k = 0; k < D; k++) r[7*k +: 7] = ~7'h40;
    end else begin
      x = v;
      ndig = 1;
      while (x >= 10) begin
        x = x / 10;
        ndig++;
      end
      x = v;
      for (int k = 0; k < D; k++) begin
        r[7*k +: 7] = (k < ndig) ? ~SEG_AH[x % 10] : ~7'h00;
        x = x / 10;
      end
    end
    return r;
  endfunction

  function automatic bit model_ovf(input logic [31:0] v, input bit dec);
    return dec && (v >= 32'd100000000);
  endfunction

  // Drive inputs and count busy cycles until idle again.
  task automatic apply_and_wait(input logic [31:0] v, input bit dec, output int cyc,
                                output bit tout);
    value_in = v;
    mode_dec = dec;
    cyc = 0;
    tout = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) cyc++;
      else begin
        tout = 1'b0;
        break;
      end
    end
    prev_v = v;
    prev_dec = dec;
    prev_pending = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    bit tout;
    rst = 1'b1;
    value_in = 32'h0;
    mode_dec = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (hex_out !== {D{7'h7F}}) begin
      errors++;
      $display("FAIL reset_hex_out: got %h want %h", hex_out, {D{7'h7F}});
    end
    checks++;
    if (busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b ovf=%b want 0 0", busy, overflow);
    end
    rst = 1'b0;
    // Pending conversion of 0 in hex runs on the first edge.
    apply_and_wait(32'h0, 1'b0, cyc, tout);
    checks++;
    if (tout || cyc != 1) begin
      errors++;
      $display("FAIL reset_first_conv: got busy cycles %0d timeout=%0b want 1", cyc, tout);
    end
    checks++;
    if (hex_out !== {D{7'h40}}) begin
      errors++;
      $display("FAIL reset_first_disp: got %h want %h", hex_out, {D{7'h40}});
    end
  endtask

  task automatic test_hex();
    int cyc;
    bit tout;
    logic [D*7-1:0] exp;
    exp = {~7'h5E, ~7'h79, ~7'h77, ~7'h5E, ~7'h7C, ~7'h79, ~7'h79, ~7'h71};
    apply_and_wait(32'hDEADBEEF, 1'b0, cyc, tout);
    checks++;
    if (tout || cyc != 1) begin
      errors++;
      $display("FAIL hex_busy: got %0d cycles timeout=%0b want 1", cyc, tout);
    end
    checks++;
    if (hex_out !== exp || overflow !== 1'b0) begin
      errors++;
      $display("FAIL hex_disp: got %h ovf=%b want %h ovf=0", hex_out, overflow, exp);
    end
  endtask

  task automatic test_dec();
    int cyc;
    bit tout;
    logic [D*7-1:0] exp;
    exp = {~7'h06, ~7'h5B, ~7'h4F, ~7'h66, ~7'h6D, ~7'h7D, ~7'h07, ~7'h7F};
    apply_and_wait(32'd12345678, 1'b1, cyc, tout);
    checks++;
    if (tout || cyc != 33) begin
      errors++;
      $display("FAIL dec_busy: got %0d cycles timeout=%0b want 33", cyc, tout);
    end
    checks++;
    if (hex_out !== exp || overflow !== 1'b0) begin
      errors++;
      $display("FAIL dec_disp: got %h ovf=%b want %h ovf=0", hex_out, overflow, exp);
    end
  endtask

  task automatic test_dec_overflow();
    int cyc;
    bit tout;
    logic [D*7-1:0] exp0;
    exp0 = {{(D-1){7'h7F}}, 7'h40};
    apply_and_wait(32'd100000000, 1'b1, cyc, tout);
    checks++;
    if (tout || hex_out !== {D{7'h3F}} || overflow !== 1'b1) begin
      errors++;
      $display("FAIL dec_ovf: got %h ovf=%b want %h ovf=1", hex_out, overflow, {D{7'h3F}});
    end
    apply_and_wait(32'd0, 1'b1, cyc, tout);
    checks++;
    if (tout || hex_out !== exp0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL dec_zero: got %h ovf=%b want %h ovf=0", hex_out, overflow, exp0);
    end
  endtask

  task automatic test_mid_change();
    int n;
    bit done;
    value_in = 32'd42;
    mode_dec = 1'b1;
    repeat (10) @(negedge clk);
    value_in = 32'd99;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    checks++;
    if (!done || hex_out !== model_disp(32'd42, 1'b1)) begin
      errors++;
      $display("FAIL mid_first: got %h done=%0b want %h", hex_out, done,
               model_disp(32'd42, 1'b1));
    end
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      n++;
      if (!busy) done = 1'b1;
    end
    checks++;
    if (!done || n != 34) begin
      errors++;
      $display("FAIL mid_second_latency: got %0d cycles done=%0b want 34", n, done);
    end
    checks++;
    if (hex_out !== model_disp(32'd99, 1'b1)) begin
      errors++;
      $display("FAIL mid_second_disp: got %h want %h", hex_out, model_disp(32'd99, 1'b1));
    end
    prev_v = 32'd99;
    prev_dec = 1'b1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit tout;
    value_in = 32'd777777;
    mode_dec = 1'b1;
    repeat (16) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (hex_out !== {D{7'h7F}} || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got %h busy=%b ovf=%b want %h 0 0", hex_out, busy, overflow,
               {D{7'h7F}});
    end
    @(negedge clk);
    rst = 1'b0;
    apply_and_wait(32'd777777, 1'b1, cyc, tout);
    checks++;
    if (tout || cyc != 33 || hex_out !== model_disp(32'd777777, 1'b1)) begin
      errors++;
      $display("FAIL reset_mid_resume: got %h cycles=%0d want %h cycles=33", hex_out, cyc,
               model_disp(32'd777777, 1'b1));
    end
  endtask

  task automatic test_mode_toggle();
    int cyc;
    bit tout;
    logic [D*7-1:0] exp_dec;
    logic [D*7-1:0] exp_hex;
    exp_dec = {{(D-3){7'h7F}}, ~7'h5B, ~7'h6D, ~7'h6D};
    exp_hex = {{(D-2){7'h40}}, ~7'h71, ~7'h71};
    apply_and_wait(32'd255, 1'b1, cyc, tout);
    checks++;
    if (tout || cyc != 33 || hex_out !== exp_dec) begin
      errors++;
      $display("FAIL toggle_dec1: got %h cycles=%0d want %h cycles=33", hex_out, cyc, exp_dec);
    end
    apply_and_wait(32'd255, 1'b0, cyc, tout);
    checks++;
    if (tout || cyc != 1 || hex_out !== exp_hex) begin
      errors++;
      $display("FAIL toggle_hex: got %h cycles=%0d want %h cycles=1", hex_out, cyc, exp_hex);
    end
    apply_and_wait(32'd255, 1'b1, cyc, tout);
    checks++;
    if (tout || cyc != 33 || hex_out !== exp_dec) begin
      errors++;
      $display("FAIL toggle_dec2: got %h cycles=%0d want %h cycles=33", hex_out, cyc, exp_dec);
    end
  endtask

  task automatic test_random();
    int cyc;
    int exp_cyc;
    bit tout;
    logic [31:0] v;
    bit dec;
    bit same;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        v = prev_v;
        dec = prev_dec;
      end else begin
        v = $urandom >> $urandom_range(0, 31);
        dec = ($urandom_range(0, 2) != 0);
      end
      same = (v == prev_v) && (dec == prev_dec) && !prev_pending;
      exp_cyc = same ? 0 : (dec ? 33 : 1);
      apply_and_wait(v, dec, cyc, tout);
      checks++;
      if (tout || cyc != exp_cyc) begin
        errors++;
        $display("FAIL rand_busy[%0d]: v=%0d dec=%0b got %0d cycles want %0d", it, v, dec, cyc,
                 exp_cyc);
      end
      checks++;
      if (hex_out !== model_disp(v, dec) || overflow !== model_ovf(v, dec)) begin
        errors++;
        $display("FAIL rand_disp[%0d]: v=%0d dec=%0b got %h ovf=%b want %h ovf=%b", it, v, dec,
                 hex_out, overflow, model_disp(v, dec), model_ovf(v, dec));
      end
    end
  endtask

  initial begin
    prev_v = 32'h0;
    prev_dec = 1'b0;
    prev_pending = 1'b1;
    test_reset();
    test_hex();
    test_dec();
    test_dec_overflow();
    test_mid_change();
    test_reset_mid();
    test_mode_toggle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
